// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// pipe_ctrl_pkg
// Shared types and helpers for the five-stage pipeline hazard controller.
// Revision: 1.0
// ============================================================================
package pipe_ctrl_pkg;

    localparam int CNT_W_DEFAULT = 16;

    typedef enum logic [1:0] {
        FWD_REGF  = 2'b00,
        FWD_EXMEM = 2'b10,
        FWD_MEMWB = 2'b01,
        FWD_RET   = 2'b11
    } fwd_sel_e;

    typedef enum logic [0:0] {
        ST_RUN    = 1'b0,
        ST_FROZEN = 1'b1
    } state_e;

    typedef struct packed {
        logic [4:0] rd;
        logic       we;
        logic       load;
    } sb_entry_t;

    // $0 is hardwired, so a write to it never creates a dependency.
    function automatic logic sb_match(input sb_entry_t e, input logic [4:0] r, input logic use_r);
        return use_r && e.we && (e.rd != 5'd0) && (e.rd == r);
    endfunction

    function automatic fwd_sel_e fwd_pick(input sb_entry_t mem, input sb_entry_t wb,
                                          input sb_entry_t ret, input logic [4:0] r,
                                          input logic use_r);
        if (sb_match(mem, r, use_r))      return FWD_EXMEM;
        else if (sb_match(wb, r, use_r))  return FWD_MEMWB;
        else if (sb_match(ret, r, use_r)) return FWD_RET;
        else                              return FWD_REGF;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hz_sat_counter.sv
`default_nettype none
// ============================================================================
// hz_sat_counter
// Event counter that increments on enable and sticks at all-ones.
// Revision: 1.0
// ============================================================================
module hz_sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_n,
    input  logic             en_i,
    output logic [WIDTH-1:0] cnt_o
);

    localparam logic [WIDTH-1:0] c_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_cnt;

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (en_i && (r_cnt != '1)) begin
            r_cnt <= r_cnt + c_ONE;
        end
    end

    assign cnt_o = r_cnt;

endmodule
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// pipe_hazard_ctrl
// Stall/flush/freeze sequencing and EX forwarding selects for a 5-stage MIPS.
// Revision: 1.0
// ============================================================================
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk_i,
    input  logic             rst_n,
    input  logic [4:0]       id_rs_i,
    input  logic [4:0]       id_rt_i,
    input  logic             id_use_rs_i,
    input  logic             id_use_rt_i,
    input  logic [4:0]       id_rd_i,
    input  logic             id_regwrite_i,
    input  logic             id_memread_i,
    input  logic             ex_redirect_i,
    input  logic             mem_busy_i,
    output logic             pc_we_o,
    output logic             ifid_we_o,
    output logic             ifid_flush_o,
    output logic             idex_bubble_o,
    output logic             exmem_we_o,
    output logic             memwb_we_o,
    output logic [1:0]       fwd_a_o,
    output logic [1:0]       fwd_b_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    state_e    r_state;
    state_e    w_state_nxt;
    sb_entry_t r_ex, r_mem, r_wb, r_ret;
    logic [4:0] r_ex_rs, r_ex_rt;
    logic       r_ex_use_rs, r_ex_use_rt;

    logic w_frozen, w_redirect, w_load_use, w_stall;
    logic w_unused_ret_load;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_RUN:    if (mem_busy_i)  w_state_nxt = ST_FROZEN;
            ST_FROZEN: if (!mem_busy_i) w_state_nxt = ST_RUN;
            default:   w_state_nxt = ST_RUN;
        endcase
    end

    // Gating with rst_n makes the outputs show reset values while reset is held,
    // even if mem_busy_i or ex_redirect_i are still asserted.
    assign w_frozen   = rst_n & (w_state_nxt == ST_FROZEN);
    assign w_redirect = rst_n & ~w_frozen & ex_redirect_i;
    assign w_load_use = rst_n & r_ex.load &
                        (sb_match(r_ex, id_rs_i, id_use_rs_i) | sb_match(r_ex, id_rt_i, id_use_rt_i));
    assign w_stall    = w_load_use & ~w_frozen & ~w_redirect;

    assign pc_we_o       = ~w_frozen & ~w_stall;
    assign ifid_we_o     = ~w_frozen & ~w_stall;
    assign ifid_flush_o  = w_redirect;
    assign idex_bubble_o = w_redirect | w_stall;
    assign exmem_we_o    = ~w_frozen;
    assign memwb_we_o    = ~w_frozen;

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_RUN;
            r_ex        <= '0;
            r_mem       <= '0;
            r_wb        <= '0;
            r_ret       <= '0;
            r_ex_rs     <= 5'd0;
            r_ex_rt     <= 5'd0;
            r_ex_use_rs <= 1'b0;
            r_ex_use_rt <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (!w_frozen) begin
                r_ret <= r_wb;
                r_wb  <= r_mem;
                r_mem <= r_ex;
                if (idex_bubble_o) begin
                    r_ex        <= '0;
                    r_ex_rs     <= 5'd0;
                    r_ex_rt     <= 5'd0;
                    r_ex_use_rs <= 1'b0;
                    r_ex_use_rt <= 1'b0;
                end else begin
                    r_ex        <= '{rd: id_rd_i, we: id_regwrite_i, load: id_memread_i};
                    r_ex_rs     <= id_rs_i;
                    r_ex_rt     <= id_rt_i;
                    r_ex_use_rs <= id_use_rs_i;
                    r_ex_use_rt <= id_use_rt_i;
                end
            end
        end
    end

    assign fwd_a_o = fwd_pick(r_mem, r_wb, r_ret, r_ex_rs, r_ex_use_rs);
    assign fwd_b_o = fwd_pick(r_mem, r_wb, r_ret, r_ex_rt, r_ex_use_rt);

    // The retired slot's load flag has no consumer; it is kept for slot symmetry.
    assign w_unused_ret_load = r_ret.load;

    hz_sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
        .clk_i (clk_i),
        .rst_n (rst_n),
        .en_i  (w_stall),
        .cnt_o (stall_cnt_o)
    );

    hz_sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
        .clk_i (clk_i),
        .rst_n (rst_n),
        .en_i  (w_redirect),
        .cnt_o (flush_cnt_o)
    );

endmodule
`default_nettype wire

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Hazard and sequencing controller for the five-stage MIPS pipeline (IF, ID, EX, MEM, WB).
- Tracks in-flight destination registers in an internal scoreboard.
- Drives the PC and pipeline-register enables, load-use bubbles, redirect flushes, data-memory freeze and EX-stage forwarding selects.
- Counts stall and flush events.
- Sits beside the datapath: consumes decoded ID fields, EX redirect and memory-busy status; owns no datapath registers.

## Interface
- CNT_W, 16, width of the saturating stall/flush event counters
- clk_i  in  1  clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- id_rs_i, id_rt_i  in  5 each  source register numbers of the instruction in ID
- id_use_rs_i, id_use_rt_i  in  1 each  ID instruction actually reads rs / rt
- id_rd_i  in  5  destination after RegDst mux
- id_regwrite_i  in  1  ID instruction writes the register file
- id_memread_i  in  1  ID instruction is a load
- ex_redirect_i  in  1  taken branch or jump resolved in EX this cycle
- mem_busy_i  in  1  data memory not ready; whole pipeline must hold
- pc_we_o  out  1  PC load enable
- ifid_we_o  out  1  IF/ID register enable
- ifid_flush_o  out  1  IF/ID loads a NOP
- idex_bubble_o  out  1  ID/EX loads a NOP (control bits cleared)
- exmem_we_o, memwb_we_o  out  1 each  later stage-register enables
- fwd_a_o, fwd_b_o  out  2 each  EX operand source: 00 register file, 10 EX/MEM, 01 MEM/WB, 11 retired-result latch
- stall_cnt_o, flush_cnt_o  out  CNT_W each  saturating event counters

## Operation
**Scoreboard**
- Four slots: EX, MEM, WB, RET. Each slot holds rd, we, load; EX also holds rs, rt, use_rs, use_rt.
- Each advancing cycle the slots shift EX→MEM→WB→RET.
- EX loads the ID fields, or a zero entry when idex_bubble_o=1.
- Frozen cycle: all slots hold.

**Register 0**
- rd=0 never matches for hazards or forwarding.

**FSM states**
- RUN: normal.
- FROZEN: entered on mem_busy_i=1. While in FROZEN:
  - every *_we_o=0, flush/bubble=0.
  - ex_redirect_i is ignored; the datapath holds EX stable.
  - Returns to RUN on the first cycle mem_busy_i=0, and that cycle is evaluated as RUN.

**Load-use hazard (RUN)**
- Condition: EX slot has load=1, we=1, rd≠0, and (use_rs & rs==rd or use_rt & rt==rd).
- Response: pc_we_o=0, ifid_we_o=0, idex_bubble_o=1, exmem/memwb_we_o=1.
- Lasts exactly one cycle; stall_cnt_o+1.

**Redirect (RUN)**
- ex_redirect_i=1 → pc_we_o=1, ifid_flush_o=1, idex_bubble_o=1; flush_cnt_o+1.
- Redirect overrides a same-cycle load-use stall: no stall count.

**Priority**
- reset > mem_busy_i > redirect > load-use > normal.

**Forwarding** (per EX operand; combinational from slot state)
- Youngest match wins: MEM (10), then WB (01), then RET (11), else 00.
- A slot matches when we=1, rd≠0, and rd equals the operand register with its use bit set.
- RET covers the register-file write-then-read gap. The datapath latches the last WB write data.

**Counters**
- Saturate at all-ones; no wrap.

## Timing
- Enables, flush, bubble: combinational from state and inputs, same cycle.
- fwd_*: combinational from registered slots only.
- Scoreboard and counters update on the rising edge.

**Reset values** (asynchronous, active-low)
- All slots zero, state RUN, counters 0.
- Outputs: pc_we_o=1, ifid_we_o=1, exmem/memwb_we_o=1, flush/bubble=0, fwd=00.

**Boundary conditions**
- Reset asserted mid-stall or mid-freeze: immediate return to the reset values. No pending stall survives.
- mem_busy_i and ex_redirect_i both high: freeze only. The redirect is acted on in the first RUN cycle.
- Load-use on both operands: still a single one-cycle stall.

## Structure
- Package pipe_ctrl_pkg:
  - fwd_sel_e encodings (REGF, EXMEM, MEMWB, RET)
  - state_e (RUN, FROZEN)
  - sb_entry_t struct {rd, we, load}
  - CNT_W default
- One sub-module: hz_sat_counter (CNT_W-bit saturating incrementer with enable), instantiated twice.

## Test plan
- **Load-use:** lw $8,0($0) then add $9,$8,$1.
  - ID-of-add cycle: pc_we_o=0, ifid_we_o=0, idex_bubble_o=1.
  - add in EX: fwd_a_o=01.
  - stall_cnt_o=1.
- **EX/MEM and WB forwarding:** add $3,$1,$2; sub $4,$3,$3.
  - sub in EX: fwd_a_o=fwd_b_o=10, no stall.
  - One NOP inserted between them → 01.
  - Two NOPs → 11.
- **Register 0:** add $0,$1,$2; or $5,$0,$0 → fwd=00; lw to $0 followed by a use → no stall.
- **Redirect:** ex_redirect_i=1 with load-use also present → ifid_flush_o=1, idex_bubble_o=1, pc_we_o=1, flush_cnt_o=1, stall_cnt_o=0.
- **Freeze:** mem_busy_i high 3 cycles with ex_redirect_i=1.
  - All enables 0 for those 3 cycles; slots unchanged.
  - Flush occurs in the 4th cycle.
- **Reset and saturation:**
  - Deassert rst_n during a freeze → outputs at reset values immediately.
  - CNT_W=4 with 20 load-use stalls → stall_cnt_o=15.
